pos_cell_access_ctrl: RTL and testbench

//  Sequences one cell position RAM (single-port, 2-cycle read latency, word 0 = particle count,

---
 rtl/pos_cell_if.sv | 28 ++
 rtl/pos_cell_access_ctrl.sv | 153 +++++++++++++++
 tb/tb_pos_cell_access_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pos_cell_if.sv
// Client-side bundle for the cell position RAM controller: streaming read and write-back ports.
interface pos_cell_if #(
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  rd_start;
  logic                  rd_busy;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] rd_pid;
  logic                  rd_last;
  logic                  rd_done;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ack;
  logic                  cnt_err;

  modport master (
    output rd_start, wr_req, wr_addr, wr_data,
    input  rd_busy, rd_valid, rd_data, rd_pid, rd_last, rd_done, wr_ack, cnt_err
  );

  modport slave (
    input  rd_start, wr_req, wr_addr, wr_data,
    output rd_busy, rd_valid, rd_data, rd_pid, rd_last, rd_done, wr_ack, cnt_err
  );
endinterface

// File: rtl/pos_cell_access_ctrl.sv
// Owns the single-port cell position RAM: streams count + particles to the force pipeline and
// slots motion-update write-backs in while idle.
module pos_cell_access_ctrl #(
  parameter int unsigned DATA_WIDTH   = 96,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pos_cell_if.slave             bus,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam logic [ADDR_WIDTH-1:0] MaxCnt  = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    StIdle, StRdCnt, StWaitCnt, StStream, StDrain, StDone
  } state_e;

  state_e                state_q;
  logic                  rd_pend_q;
  logic [1:0]            wait_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  cnt_err_q;
  logic                  rd_done_q;
  // p0 is aligned with the RAM pins, s2 with mem_q
  logic                  p0_v, p0_last;
  logic                  s1_v, s1_last, s2_v, s2_last;
  logic [ADDR_WIDTH-1:0] s1_pid, s2_pid;
  logic [ADDR_WIDTH-1:0] q_cnt, cnt_new, addr_inc;

  assign q_cnt = mem_q[ADDR_WIDTH-1:0];

  always_comb begin
    cnt_new  = (q_cnt > MaxCnt) ? MaxCnt : q_cnt;
    addr_inc = mem_address + AddrOne;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rd_pend_q   <= 1'b0;
      wait_q      <= '0;
      cnt_q       <= '0;
      cnt_err_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_rden    <= 1'b0;
      mem_wren    <= 1'b0;
      p0_v        <= 1'b0;
      p0_last     <= 1'b0;
    end else begin
      mem_rden  <= 1'b0;
      mem_wren  <= 1'b0;
      p0_v      <= 1'b0;
      p0_last   <= 1'b0;
      rd_done_q <= 1'b0;
      if (bus.rd_start) rd_pend_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (bus.wr_req) begin
            mem_wren    <= 1'b1;
            mem_address <= bus.wr_addr;
            mem_data    <= bus.wr_data;
          end else if (rd_pend_q || bus.rd_start) begin
            state_q <= StRdCnt;
          end
        end
        StRdCnt: begin
          mem_rden    <= 1'b1;
          mem_address <= '0;
          wait_q      <= '0;
          state_q     <= StWaitCnt;
        end
        StWaitCnt: begin
          wait_q <= wait_q + 2'd1;
          if (wait_q == 2'd2) begin
            cnt_q <= cnt_new;
            if (q_cnt > MaxCnt) cnt_err_q <= 1'b1;
            if (cnt_new == '0) begin
              rd_done_q <= 1'b1;
              state_q   <= StDone;
            end else begin
              mem_rden    <= 1'b1;
              mem_address <= AddrOne;
              p0_v        <= 1'b1;
              p0_last     <= (cnt_new == AddrOne);
              state_q     <= StStream;
            end
          end
        end
        StStream: begin
          if (mem_address == cnt_q) begin
            wait_q  <= '0;
            state_q <= StDrain;
          end else begin
            mem_rden    <= 1'b1;
            mem_address <= addr_inc;
            p0_v        <= 1'b1;
            p0_last     <= (addr_inc == cnt_q);
          end
        end
        StDrain: begin
          // Hold two cycles past the final beat so rd_done trails rd_last by three cycles
          wait_q <= wait_q + 2'd1;
          if (wait_q == 2'd3 && !s1_v && !s2_v) begin
            rd_done_q <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          rd_pend_q <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_pid  <= '0;
      s1_last <= 1'b0;
      s2_v    <= 1'b0;
      s2_pid  <= '0;
      s2_last <= 1'b0;
    end else begin
      s1_v    <= p0_v;
      s1_pid  <= mem_address;
      s1_last <= p0_last;
      s2_v    <= s1_v;
      s2_pid  <= s1_pid;
      s2_last <= s1_last;
    end
  end

  assign bus.rd_busy  = rd_pend_q | (state_q != StIdle);
  assign bus.rd_valid = s2_v;
  assign bus.rd_pid   = s2_v ? s2_pid : '0;
  assign bus.rd_last  = s2_v & s2_last;
  assign bus.rd_data  = s2_v ? mem_q : '0;
  assign bus.rd_done  = rd_done_q;
  assign bus.wr_ack   = (state_q == StIdle) & bus.wr_req;
  assign bus.cnt_err  = cnt_err_q;

endmodule

// File: tb/tb_pos_cell_access_ctrl.sv
// Directed bench for pos_cell_access_ctrl with a 2-cycle-latency RAM model.
module tb_pos_cell_access_ctrl;
  localparam int unsigned DW = 96;
  localparam int unsigned AW = 8;
  localparam int unsigned PN = 220;

  localparam logic [DW-1:0] DA = 96'h0A0A0A0A_1B1B1B1B_2C2C2C2C;
  localparam logic [DW-1:0] DB = 96'h11111111_22222222_33333333;
  localparam logic [DW-1:0] DC = 96'hDEADBEEF_CAFEF00D_01234567;
  localparam logic [DW-1:0] DX = 96'h55AA55AA_AA55AA55_0F0F0F0F;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data, mem_q, q_p1, q_p2;
  logic          mem_rden, mem_wren;
  logic [DW-1:0] ram     [0:255];
  logic [DW-1:0] exp_mem [0:255];

  int n_checks = 0;
  int n_errors = 0;
  int beats, first_c, last_c, last_pid, done_c, n_done, ack_c;
  int busy_first, busy_last, busy_cnt, bad_pid, bad_data, rden_hi, both_c, cnt_rd_c;
  int quiet;

  pos_cell_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  pos_cell_access_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .PARTICLE_NUM(PN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_rden   (mem_rden),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    q_p1 <= mem_rden ? ram[mem_address] : '0;
    q_p2 <= q_p1;
  end
  assign mem_q = q_p2;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [DW-1:0] d);
    ram[a]     = d;
    exp_mem[a] = d;
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return {32'(i) + 32'h1000, 32'(i * 7), 32'(i) ^ 32'hFFFF};
  endfunction

  // rd_start is raised in cycle 0; every cycle up to max_c is observed
  task automatic run_read(input int max_c, input int wr_c, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd);
    bit acked;
    beats = 0; first_c = -1; last_c = -1; last_pid = -1; done_c = -1; n_done = 0; ack_c = -1;
    busy_first = -1; busy_last = -1; busy_cnt = 0; bad_pid = 0; bad_data = 0; rden_hi = 0;
    both_c = 0; cnt_rd_c = -1;
    bus.rd_start = 1'b1;
    for (int c = 0; c <= max_c; c++) begin
      acked = 1'b0;
      if (c == wr_c) begin
        bus.wr_req  = 1'b1;
        bus.wr_addr = wa;
        bus.wr_data = wd;
      end
      #1;
      if (bus.rd_valid) begin
        beats++;
        if (first_c < 0) first_c = c;
        if (int'(bus.rd_pid) != beats) bad_pid++;
        if (bus.rd_data !== exp_mem[bus.rd_pid]) bad_data++;
        if (bus.rd_last) begin
          last_c   = c;
          last_pid = int'(bus.rd_pid);
        end
      end
      if (bus.rd_done) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      if (bus.wr_ack) begin
        acked = 1'b1;
        if (ack_c < 0) ack_c = c;
      end
      if (bus.rd_busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (mem_rden && mem_address != '0) rden_hi++;
      if (mem_rden && mem_address == '0 && cnt_rd_c < 0) cnt_rd_c = c;
      if (mem_rden && mem_wren) both_c++;
      step();
      bus.rd_start = 1'b0;
      if (acked) bus.wr_req = 1'b0;
    end
  endtask

  initial begin
    bus.rd_start = 1'b0;
    bus.wr_req   = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    for (int i = 0; i < 256; i++) load(i, '0);

    // Reset state
    #1;
    chk("rst rd_busy", bus.rd_busy, 0);
    chk("rst rd_valid", bus.rd_valid, 0);
    chk("rst cnt_err", bus.cnt_err, 0);
    chk("rst mem_address", mem_address, 0);
    chk("rst mem_rden", mem_rden, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // 1 + 3: three-particle stream, write held from cycle 3 is deferred until idle
    load(0, 96'd3); load(1, DA); load(2, DB); load(3, DC);
    run_read(16, 3, 8'd2, DX);
    chk("t1 count read cycle", cnt_rd_c, 2);
    chk("t1 first valid", first_c, 7);
    chk("t1 beats", beats, 3);
    chk("t1 pid order", bad_pid, 0);
    chk("t1 data", bad_data, 0);
    chk("t1 last cycle", last_c, 9);
    chk("t1 last pid", last_pid, 3);
    chk("t1 done cycle", done_c, 12);
    chk("t1 done count", n_done, 1);
    chk("t1 busy first", busy_first, 1);
    chk("t1 busy last", busy_last, 12);
    chk("t1 busy span", busy_cnt, 12);
    chk("t3 ack cycle", ack_c, 13);
    chk("t1 rden&wren", both_c, 0);
    chk("t1 cnt_err", bus.cnt_err, 0);
    step();
    exp_mem[2] = DX;
    run_read(14, -1, '0, '0);
    chk("t3 rerun beats", beats, 3);
    chk("t3 rerun data", bad_data, 0);
    chk("t3 rerun done", done_c, 12);
    chk("t3 rerun no ack", ack_c, -1);

    // 2: empty cell
    load(0, 96'd0);
    run_read(10, -1, '0, '0);
    chk("t2 done cycle", done_c, 5);
    chk("t2 beats", beats, 0);
    chk("t2 particle reads", rden_hi, 0);
    chk("t2 count read cycle", cnt_rd_c, 2);
    chk("t2 busy last", busy_last, 5);
    chk("t2 done count", n_done, 1);

    // 4: count write and read start together, write goes first and is seen by the read
    run_read(14, 0, 8'd0, 96'd1);
    chk("t4 ack cycle", ack_c, 0);
    chk("t4 beats", beats, 1);
    chk("t4 first valid", first_c, 8);
    chk("t4 last pid", last_pid, 1);
    chk("t4 done cycle", done_c, 11);
    chk("t4 data", bad_data, 0);

    // 5: oversized count is clamped
    load(0, 96'd250);
    for (int i = 1; i < int'(PN); i++) load(i, pat(i));
    run_read(240, -1, '0, '0);
    chk("t5 beats", beats, 219);
    chk("t5 first valid", first_c, 7);
    chk("t5 last cycle", last_c, 225);
    chk("t5 last pid", last_pid, 219);
    chk("t5 done cycle", done_c, 228);
    chk("t5 pid order", bad_pid, 0);
    chk("t5 data", bad_data, 0);
    chk("t5 particle reads", rden_hi, 219);
    chk("t5 cnt_err", bus.cnt_err, 1);
    load(0, 96'd2);
    run_read(14, -1, '0, '0);
    chk("t5 sticky beats", beats, 2);
    chk("t5 sticky cnt_err", bus.cnt_err, 1);

    // 6: reset in the middle of a stream
    load(0, 96'd3); load(1, DA); load(2, DB); load(3, DC);
    bus.rd_start = 1'b1;
    step();
    bus.rd_start = 1'b0;
    repeat (5) step();
    chk("t6 streaming rden", mem_rden, 1);
    chk("t6 streaming addr", mem_address, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 rst rd_busy", bus.rd_busy, 0);
    chk("t6 rst mem_rden", mem_rden, 0);
    chk("t6 rst mem_address", mem_address, 0);
    chk("t6 rst rd_valid", bus.rd_valid, 0);
    chk("t6 rst cnt_err", bus.cnt_err, 0);
    repeat (3) step();
    rst_n = 1'b1;
    quiet = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.rd_done || bus.rd_valid || bus.rd_busy) quiet++;
      step();
    end
    chk("t6 no activity after reset", quiet, 0);
    run_read(14, -1, '0, '0);
    chk("t6 fresh beats", beats, 3);
    chk("t6 fresh first valid", first_c, 7);
    chk("t6 fresh data", bad_data, 0);
    chk("t6 fresh done", done_c, 12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
